// File: rtl/prbs_pkg.sv
// Shared types, polynomial table and constants for the PRBS generator/checker.
package prbs_pkg;

    localparam int MAX_N = 31;

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } prbs_mode_e;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    function automatic logic [4:0] prbs_len(prbs_mode_e m);
        case (m)
            PRBS7:   return 5'd7;
            PRBS15:  return 5'd15;
            PRBS23:  return 5'd23;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(prbs_mode_e m);
        case (m)
            PRBS7:   return 5'd6;
            PRBS15:  return 5'd14;
            PRBS23:  return 5'd18;
            default: return 5'd28;
        endcase
    endfunction

endpackage

// File: rtl/prbs_gen_chk_step.sv
// Combinational W-step advance of a 31-bit PRBS register. With FEED=0 the
// feedback bit is shifted in (generator); with FEED=1 the received bit is.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int W    = 8,
    parameter bit FEED = 1'b0
) (
    input  logic [1:0]       mode,
    input  logic [MAX_N-1:0] state,
    input  logic [W-1:0]     din,
    output logic [MAX_N-1:0] next_state,
    output logic [W-1:0]     bits
);

    logic [4:0]       n_len;
    logic [4:0]       t_tap;
    logic [MAX_N-1:0] s;
    logic             fb;

    assign n_len = prbs_len(prbs_mode_e'(mode));
    assign t_tap = prbs_tap(prbs_mode_e'(mode));

    always_comb begin
        s    = state;
        bits = '0;
        fb   = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            fb      = s[n_len - 5'd1] ^ s[t_tap - 5'd1];
            bits[i] = fb;
            s       = {s[MAX_N-2:0], (FEED ? din[i] : fb)};
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS generator plus self-synchronising checker with HUNT/LOCKED lock
// tracking and a saturating bit-error counter.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int W            = 8,
    parameter int CW           = 16,
    parameter int LOCK_WORDS   = 4,
    parameter int UNLOCK_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          gen_en,
    input  logic          inj_err,
    output logic          gen_valid,
    output logic [W-1:0]  gen_data,
    input  logic          chk_valid,
    input  logic [W-1:0]  chk_data,
    input  logic          cnt_clr,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_count
);

    localparam int GW = $clog2(LOCK_WORDS + 1);
    localparam int BW = $clog2(UNLOCK_WORDS + 1);
    localparam int SW = ((CW > 6) ? CW : 6) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CW{1'b1}});

    prbs_mode_e       mode_q;
    logic             mode_chg;
    logic [MAX_N-1:0] gen_s, gen_s_nxt, hist, hist_nxt;
    logic [W-1:0]     gen_bits, pred, err_bits;
    logic             word_err;
    logic [5:0]       err_pop, fill_need, fill_cnt, fill_d;
    logic [SW-1:0]    err_sum;
    lock_state_e      state, state_d;
    logic [GW-1:0]    good_cnt, good_d;
    logic [BW-1:0]    bad_cnt, bad_d;

    prbs_lfsr_step #(.W(W), .FEED(1'b0)) u_gen_step (
        .mode       (mode_q),
        .state      (gen_s),
        .din        ('0),
        .next_state (gen_s_nxt),
        .bits       (gen_bits)
    );

    prbs_lfsr_step #(.W(W), .FEED(1'b1)) u_chk_step (
        .mode       (mode_q),
        .state      (hist),
        .din        (chk_data),
        .next_state (hist_nxt),
        .bits       (pred)
    );

    assign mode_chg  = (prbs_mode_e'(mode) != mode_q);
    assign err_bits  = chk_data ^ pred;
    assign word_err  = |err_bits;
    assign fill_need = (6'(prbs_len(mode_q)) + 6'(W - 1)) / 6'(W);
    assign err_sum   = SW'(err_count) + SW'(err_pop);
    assign locked    = (state == LOCKED);

    always_comb begin
        err_pop = '0;
        for (int unsigned i = 0; i < W; i++) begin
            err_pop = err_pop + 6'(err_bits[i]);
        end
    end

    // Fill words only prime the history; they neither count nor reset good_cnt.
    always_comb begin
        state_d = state;
        fill_d  = fill_cnt;
        good_d  = good_cnt;
        bad_d   = bad_cnt;
        if (mode_chg) begin
            state_d = HUNT;
            fill_d  = '0;
            good_d  = '0;
            bad_d   = '0;
        end else if (chk_valid) begin
            unique case (state)
                HUNT: begin
                    if (fill_cnt < fill_need) begin
                        fill_d = fill_cnt + 6'd1;
                    end else if (word_err) begin
                        good_d = '0;
                    end else if (good_cnt == GW'(LOCK_WORDS - 1)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!word_err) begin
                        bad_d = '0;
                    end else if (bad_cnt == BW'(UNLOCK_WORDS - 1)) begin
                        state_d = HUNT;
                        good_d  = '0;
                        fill_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= prbs_mode_e'(mode);
            gen_s     <= '1;
            gen_valid <= 1'b0;
            gen_data  <= '0;
            hist      <= '0;
            state     <= HUNT;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            mode_q   <= prbs_mode_e'(mode);
            state    <= state_d;
            fill_cnt <= fill_d;
            good_cnt <= good_d;
            bad_cnt  <= bad_d;
            if (cnt_clr) begin
                err_count <= '0;
            end else if (!mode_chg && chk_valid && state == LOCKED) begin
                err_count <= (err_sum > CNT_MAX) ? '1 : err_sum[CW-1:0];
            end
            if (mode_chg) begin
                gen_s     <= '1;
                gen_valid <= 1'b0;
                hist      <= '0;
                err_pulse <= 1'b0;
            end else begin
                gen_valid <= gen_en;
                if (gen_en) begin
                    gen_s    <= gen_s_nxt;
                    gen_data <= gen_bits ^ W'(inj_err);
                end
                if (chk_valid) begin
                    hist <= hist_nxt;
                end
                err_pulse <= chk_valid && (state == LOCKED) && word_err;
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Self-checking bench for prbs_gen_chk: directed phases plus a randomized
// phase, all compared against a bit-stream recurrence model.
module tb_prbs_gen_chk;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int LW = 4;
    localparam int UW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          gen_en, inj_err, chk_valid, cnt_clr;
    logic [W-1:0]  chk_data;
    logic          gen_valid, locked, err_pulse;
    logic [W-1:0]  gen_data;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    prbs_gen_chk #(.W(W), .CW(CW), .LOCK_WORDS(LW), .UNLOCK_WORDS(UW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .gen_en    (gen_en),
        .inj_err   (inj_err),
        .gen_valid (gen_valid),
        .gen_data  (gen_data),
        .chk_valid (chk_valid),
        .chk_data  (chk_data),
        .cnt_clr   (cnt_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: the transmitted and received streams are kept as bit queues and
    // every new bit is derived from x[k] = x[k-N] ^ x[k-T].
    bit           gq[$];
    bit           cq[$];
    logic [1:0]   mq;
    logic         exp_gv, exp_lk, exp_pulse;
    logic [W-1:0] exp_gd;
    int           m_fill, m_good, m_bad, m_cnt;

    function automatic int plen(logic [1:0] m);
        case (m)
            2'd0:    return 7;
            2'd1:    return 15;
            2'd2:    return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int ptap(logic [1:0] m);
        case (m)
            2'd0:    return 6;
            2'd1:    return 14;
            2'd2:    return 18;
            default: return 28;
        endcase
    endfunction

    task automatic reseed();
        gq.delete();
        cq.delete();
        repeat (31) gq.push_back(1'b1);
        repeat (31) cq.push_back(1'b0);
    endtask

    task automatic model_edge();
        int n, t, errs;
        bit b, r, pulse;
        logic [W-1:0] w;
        if (rst) begin
            mq = mode;
            reseed();
            exp_gv = 1'b0; exp_gd = '0; exp_lk = 1'b0; exp_pulse = 1'b0;
            m_fill = 0; m_good = 0; m_bad = 0; m_cnt = 0;
        end else if (mode != mq) begin
            mq = mode;
            reseed();
            exp_gv = 1'b0; exp_lk = 1'b0; exp_pulse = 1'b0;
            m_fill = 0; m_good = 0; m_bad = 0;
            if (cnt_clr) m_cnt = 0;
        end else begin
            n = plen(mq);
            t = ptap(mq);
            if (gen_en) begin
                for (int i = 0; i < W; i++) begin
                    b = gq[gq.size() - n] ^ gq[gq.size() - t];
                    w[i] = b;
                    gq.push_back(b);
                end
                while (gq.size() > 40) void'(gq.pop_front());
                w[0] = w[0] ^ inj_err;
                exp_gd = w;
                exp_gv = 1'b1;
            end else begin
                exp_gv = 1'b0;
            end
            pulse = 1'b0;
            if (chk_valid) begin
                errs = 0;
                for (int i = 0; i < W; i++) begin
                    r = chk_data[i];
                    errs += int'(r ^ cq[cq.size() - n] ^ cq[cq.size() - t]);
                    cq.push_back(r);
                end
                while (cq.size() > 40) void'(cq.pop_front());
                if (!exp_lk) begin
                    if (m_fill < (n + W - 1) / W) m_fill++;
                    else if (errs != 0) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good == LW) begin exp_lk = 1'b1; m_good = 0; m_bad = 0; end
                    end
                end else begin
                    m_cnt = (m_cnt + errs > 15) ? 15 : m_cnt + errs;
                    pulse = (errs != 0);
                    if (errs == 0) m_bad = 0;
                    else begin
                        m_bad++;
                        if (m_bad == UW) begin exp_lk = 1'b0; m_good = 0; m_fill = 0; m_bad = 0; end
                    end
                end
            end
            if (cnt_clr) m_cnt = 0;
            exp_pulse = pulse;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("gen_valid", 32'(gen_valid), 32'(exp_gv));
        chk("gen_data",  32'(gen_data),  32'(exp_gd));
        chk("locked",    32'(locked),    32'(exp_lk));
        chk("err_pulse", 32'(err_pulse), 32'(exp_pulse));
        chk("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic lb(logic en);
        gen_en = en; inj_err = 1'b0; cnt_clr = 1'b0;
        chk_valid = exp_gv; chk_data = exp_gd;
    endtask

    task automatic wait_lock(string tag, int bound);
        int nvw;
        bit got;
        nvw = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            lb(1'b1);
            if (chk_valid) nvw++;
            cyc();
            if (locked === 1'b1) got = 1;
        end
        chk(tag, 32'(got && nvw <= bound), 32'd1);
    endtask

    initial begin
        logic [W-1:0] first_w;
        logic [CW-1:0] held;
        int ones, pulses, guard;

        rst = 1'b1; mode = 2'd0; gen_en = 1'b0; inj_err = 1'b0;
        chk_valid = 1'b0; chk_data = '0; cnt_clr = 1'b0;
        repeat (3) cyc();
        chk("rst_gen_valid", 32'(gen_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);

        // First PRBS7 word from the all-ones seed.
        rst = 1'b0; gen_en = 1'b1;
        cyc();
        chk("first_word", 32'(gen_data), 32'h40);
        gen_en = 1'b0;
        cyc();
        chk("hold_valid", 32'(gen_valid), 32'd0);
        chk("hold_data", 32'(gen_data), 32'h40);

        // PRBS7: 127 words = 8 full periods.
        ones = 0;
        for (int i = 0; i < 127; i++) begin
            lb(1'b1); cyc();
            if (i == 0) first_w = gen_data;
            ones += $countones(gen_data);
        end
        lb(1'b1); cyc();
        chk("prbs7_period", 32'(gen_data), 32'(first_w));
        chk("prbs7_ones", 32'(ones), 32'd512);

        // PRBS15: 32767 words = 8 full periods.
        mode = 2'd1; lb(1'b1); cyc();
        ones = 0;
        for (int i = 0; i < 32767; i++) begin
            lb(1'b1); cyc();
            if (i == 0) first_w = gen_data;
            ones += $countones(gen_data);
        end
        lb(1'b1); cyc();
        chk("prbs15_period", 32'(gen_data), 32'(first_w));
        chk("prbs15_ones", 32'(ones), 32'd131072);

        // PRBS31 loopback lock and long clean run.
        mode = 2'd3; lb(1'b1); cnt_clr = 1'b1; cyc();
        wait_lock("lock_prbs31", 10);
        for (int i = 0; i < 10000; i++) begin lb(1'b1); cyc(); end
        chk("clean_count", 32'(err_count), 32'd0);
        chk("clean_locked", 32'(locked), 32'd1);

        // Single injected error yields three counted errors.
        held = err_count;
        lb(1'b1); inj_err = 1'b1; cyc();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            lb(1'b1); cyc();
            if (err_pulse === 1'b1) pulses++;
        end
        chk("inj_count", 32'(err_count), 32'(held) + 32'd3);
        chk("inj_pulses_1to2", 32'(pulses >= 1 && pulses <= 2), 32'd1);
        chk("inj_locked", 32'(locked), 32'd1);

        // Forced 0xFF until the checker drops lock.
        guard = 0;
        while (exp_lk && guard < 12) begin
            lb(1'b1); chk_data = 8'hFF; cyc(); guard++;
        end
        chk("unlock", 32'(locked), 32'd0);
        held = err_count;
        repeat (3) begin lb(1'b1); cyc(); end
        chk("unlock_hold", 32'(err_count), 32'(held));
        wait_lock("relock", 20);

        // Saturation at 15, then clear with an error word.
        lb(1'b1); cnt_clr = 1'b1; cyc();
        for (int k = 0; k < 7; k++) begin
            lb(1'b1); inj_err = 1'b1; cyc();
            repeat (5) begin lb(1'b1); cyc(); end
        end
        chk("saturate", 32'(err_count), 32'd15);
        chk("sat_locked", 32'(locked), 32'd1);
        lb(1'b1); chk_data = exp_gd ^ 8'h01; cnt_clr = 1'b1; cyc();
        chk("clr_priority", 32'(err_count), 32'd0);
        repeat (6) begin lb(1'b1); cyc(); end
        chk("after_clr", 32'(err_count), 32'd2);

        // Mode change mid-stream: inputs dropped, count kept, re-lock.
        mode = 2'd2; lb(1'b1); cyc();
        chk("mchg_valid", 32'(gen_valid), 32'd0);
        chk("mchg_locked", 32'(locked), 32'd0);
        chk("mchg_count", 32'(err_count), 32'd2);
        wait_lock("lock_prbs23", 9);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            lb($urandom_range(0, 3) != 0);
            inj_err = ($urandom_range(0, 49) == 0);
            cnt_clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) chk_data = chk_data ^ 8'h10;
            cyc();
        end

        // Reset mid-operation overrides everything.
        lb(1'b1); rst = 1'b1; inj_err = 1'b1; cnt_clr = 1'b0;
        cyc();
        chk("rst_mid_valid", 32'(gen_valid), 32'd0);
        chk("rst_mid_data", 32'(gen_data), 32'd0);
        chk("rst_mid_locked", 32'(locked), 32'd0);
        chk("rst_mid_count", 32'(err_count), 32'd0);
        rst = 1'b0; lb(1'b1); cyc();
        lb(1'b0); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS generator plus self-synchronising PRBS checker for link and pad bring-up on the Tiny Tapeout wrapper.
- Polynomial is selectable at run time: PRBS7, PRBS15, PRBS23 or PRBS31.
- Both sides handle W bits per cycle.
- Checker runs a HUNT/LOCKED lock state machine and keeps a saturating bit-error counter.
- Generator supports single-bit error injection.
- The top-level wrapper maps ui_in/uio to the control and data ports.

Parameters:
- W, 8, bits produced/checked per cycle (1..32).
- CW, 16, width of the error counter.
- LOCK_WORDS, 4, consecutive error-free valid words needed to reach LOCKED.
- UNLOCK_WORDS, 4, consecutive valid words containing any error that drop LOCKED back to HUNT.

Ports:
- clk  in  1  clock; the block has one clock, clk.
- rst  in  1  reset; synchronous, active-high.
- mode  in  2  polynomial select: 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31.
- gen_en  in  1  advance the generator by W bits this cycle.
- inj_err  in  1  invert bit 0 of the next generated word.
- gen_valid  out  1  gen_data holds a new word.
- gen_data  out  W  generated bits; bit 0 is earliest in time.
- chk_valid  in  1  chk_data is valid this cycle.
- chk_data  in  W  received bits; bit 0 is earliest in time.
- cnt_clr  in  1  clear err_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  last checked word had at least one bit error while LOCKED.
- err_count  out  CW  saturating count of bit errors seen while LOCKED.

Behaviour:
- Polynomials as (N,T): PRBS7 x^7+x^6+1, PRBS15 x^15+x^14+1, PRBS23 x^23+x^18+1, PRBS31 x^31+x^28+1.
- Serial step: new = s[N-1]^s[T-1]; shift s left; new enters s[0]; output bit = new.
- Generator state is 31 bits; only s[N-1:0] is used.
- Reset: s = all ones; gen_valid=0, gen_data=0, locked=0, err_pulse=0, err_count=0; checker in HUNT; history = 0.
- Generator, when gen_en=1:
  - applies W serial steps in one cycle;
  - the registered output appears the next cycle (latency 1) with gen_valid=1;
  - gen_en=0 gives gen_valid=0, gen_data holds its value and the state is frozen.
- inj_err:
  - sampled in the same cycle as gen_en; inverts gen_data[0] of that word only, never the LFSR state;
  - ignored when gen_en=0 (no pending flag).
- Checker is self-synchronous, with a history register h of 31 bits:
  - for each received bit r, in order: pred = h[N-1]^h[T-1]; e = r^pred; then h shifts left and r enters h[0];
  - processing happens only when chk_valid=1;
  - one line bit error gives exactly 3 counted errors (at positions j, j+T, j+N).
- Lock state machine:
  - HUNT: a valid word with zero errors increments good_cnt; any error resets it to 0; good_cnt == LOCK_WORDS moves to LOCKED and clears bad_cnt.
  - The first ceil(N/W) valid words after entering HUNT fill the history; their comparison result is ignored, and they neither count toward good_cnt nor reset it.
  - LOCKED: a word with errors increments bad_cnt; a clean word resets it to 0; bad_cnt == UNLOCK_WORDS moves to HUNT and clears good_cnt and the fill count.
- locked is registered and follows state one cycle after the deciding word.
- Errors are counted only in LOCKED, including the word that causes the LOCKED->HUNT transition.
- err_count, registered:
  - adds popcount(e) of each LOCKED valid word;
  - saturates at 2^CW-1 with no wrap;
  - cnt_clr takes priority over that cycle's increment; the result is 0.
- err_pulse is registered, one cycle after the word; it is 0 while in HUNT.
- Mode change (mode differs from registered mode_q):
  - in the next cycle the generator reseeds to all ones, the checker enters HUNT and its fill count restarts;
  - err_count is kept;
  - any gen_en or chk_valid in the change cycle is dropped.
- rst asserted mid-operation: all state returns to reset values on the next edge, regardless of other inputs.

Decomposition:
- Package prbs_pkg:
  - mode enum (PRBS7/15/23/31);
  - functions prbs_len(mode) and prbs_tap(mode) returning N and T;
  - constant MAX_N=31.
- Sub-module prbs_lfsr_step: combinational W-step advance of a 31-bit state for a given mode.
  - Generator: state in, next state and W output bits out.
  - Checker: a variant driven by the received bits, producing predictions and the next history.

Test Plan:
1. rst, then mode=0, W=8, gen_en=1 for one cycle -> next cycle gen_valid=1 and gen_data=0x40 (serial 0,0,0,0,0,0,1,0).
2. W=1, PRBS7, gen_en held high -> gen_data sequence repeats with period exactly 127, never 127 zeros or a stuck state; repeat for PRBS15 with period 32767.
3. gen_data/gen_valid looped into chk_data/chk_valid, PRBS31, W=8 -> locked=1 no later than ceil(31/8)+LOCK_WORDS+2 = 10 valid words after start; err_count stays 0 over 10000 words.
4. Locked loopback, single inj_err pulse -> err_count increments by exactly 3; err_pulse is high for 1–2 words; locked stays 1.
5. Locked loopback, received data forced to 0xFF for UNLOCK_WORDS words -> locked falls to 0; err_count holds its last value; normal data afterwards re-locks.
6. err_count preset near saturation with CW=4 and errors injected -> saturates at 15; cnt_clr together with an error word -> err_count=0; a mode change mid-stream -> both sides reseed and the checker re-locks.
